// File: rtl/key_pkg.sv
// rtl/key_pkg.sv - shared state encoding and parameter checks for the key debouncer.
package key_pkg;

  localparam logic [1:0] ENC_LOW  = 2'b00;
  localparam logic [1:0] ENC_RISE = 2'b01;
  localparam logic [1:0] ENC_HIGH = 2'b11;
  localparam logic [1:0] ENC_FALL = 2'b10;

  typedef enum logic [1:0] {
    S_LOW  = ENC_LOW,
    S_RISE = ENC_RISE,
    S_HIGH = ENC_HIGH,
    S_FALL = ENC_FALL
  } key_state_e;

  // Smallest counter width w (>= 1) with 2**w >= stable.
  function automatic int min_cnt_w(input int stable);
    int w;
    w = 1;
    while ((64'(1) << w) < 64'(stable)) w++;
    return w;
  endfunction

endpackage

// File: rtl/key_debounce_ch.sv
// rtl/key_debounce_ch.sv - one channel: polarity fix, 2-flop synchroniser,
// qualification counter/FSM and registered press/release pulses.
module key_debounce_ch
  import key_pkg::*;
#(
  parameter int STABLE     = 50000,
  parameter int CNT_W      = 16,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic clk,
  input  logic clrn,
  input  logic key_in,
  output logic key_out,
  output logic key_rise,
  output logic key_fall
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE - 1);

  if (STABLE < 1 || CNT_W < min_cnt_w(STABLE)) begin : g_bad_param
    $error("key_debounce_ch: STABLE must be >= 1 and fit in CNT_W bits");
  end

  logic             w_lvl;
  logic             r_s1;
  logic             r_s2;
  logic [CNT_W-1:0] r_cnt;
  key_state_e       r_state;
  logic             r_out;
  logic             r_rise;
  logic             r_fall;

  assign w_lvl    = key_in ^ ACTIVE_LOW;
  assign key_out  = r_out;
  assign key_rise = r_rise;
  assign key_fall = r_fall;

  // The FSM only ever looks at r_s2; any reversion mid-count restarts qualification.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_s1    <= 1'b0;
      r_s2    <= 1'b0;
      r_cnt   <= '0;
      r_state <= S_LOW;
      r_out   <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_s1   <= w_lvl;
      r_s2   <= r_s1;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
      case (r_state)
        S_LOW: begin
          if (r_s2) begin
            r_state <= S_RISE;
            r_cnt   <= '0;
          end
        end
        S_RISE: begin
          if (!r_s2) begin
            r_state <= S_LOW;
          end else if (r_cnt == LAST) begin
            r_state <= S_HIGH;
            r_out   <= 1'b1;
            r_rise  <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_HIGH: begin
          if (!r_s2) begin
            r_state <= S_FALL;
            r_cnt   <= '0;
          end
        end
        S_FALL: begin
          if (r_s2) begin
            r_state <= S_HIGH;
          end else if (r_cnt == LAST) begin
            r_state <= S_LOW;
            r_out   <= 1'b0;
            r_fall  <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= S_LOW;
      endcase
    end
  end

endmodule

// File: rtl/key_debounce_sync.sv
// rtl/key_debounce_sync.sv - N independent debounced, edge-detected key inputs
// brought into the clk domain.
module key_debounce_sync
  import key_pkg::*;
#(
  parameter int N          = 4,
  parameter int STABLE     = 50000,
  parameter int CNT_W      = 16,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic         clk,
  input  logic         clrn,
  input  logic [N-1:0] key_in,
  output logic [N-1:0] key_out,
  output logic [N-1:0] key_rise,
  output logic [N-1:0] key_fall
);

  if (N < 1 || STABLE < 1 || CNT_W < min_cnt_w(STABLE)) begin : g_bad_param
    $error("key_debounce_sync: need N >= 1, STABLE >= 1 and 2**CNT_W >= STABLE");
  end

  for (genvar gi = 0; gi < N; gi++) begin : g_ch
    key_debounce_ch #(
      .STABLE    (STABLE),
      .CNT_W     (CNT_W),
      .ACTIVE_LOW(ACTIVE_LOW)
    ) u_ch (
      .clk     (clk),
      .clrn    (clrn),
      .key_in  (key_in[gi]),
      .key_out (key_out[gi]),
      .key_rise(key_rise[gi]),
      .key_fall(key_fall[gi])
    );
  end

endmodule

// File: tb/tb_key_debounce_sync.sv
// tb/tb_key_debounce_sync.sv - directed table-driven bench for key_debounce_sync.
module tb_key_debounce_sync;

  logic       clk;
  logic       clrn;
  logic [3:0] key_in;
  logic [3:0] key_out;
  logic [3:0] key_rise;
  logic [3:0] key_fall;
  logic [3:0] key_in2;
  logic [3:0] key_out2;
  logic [3:0] key_rise2;
  logic [3:0] key_fall2;

  int total = 0;
  int bad   = 0;

  key_debounce_sync #(.N(4), .STABLE(4), .CNT_W(16), .ACTIVE_LOW(1'b0)) u_dut (
    .clk     (clk),
    .clrn    (clrn),
    .key_in  (key_in),
    .key_out (key_out),
    .key_rise(key_rise),
    .key_fall(key_fall)
  );

  key_debounce_sync #(.N(4), .STABLE(4), .CNT_W(16), .ACTIVE_LOW(1'b1)) u_dut_al (
    .clk     (clk),
    .clrn    (clrn),
    .key_in  (key_in2),
    .key_out (key_out2),
    .key_rise(key_rise2),
    .key_fall(key_fall2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] in;
    logic [3:0] out;
    logic [3:0] rise;
    logic [3:0] fall;
  } vec_t;

  vec_t tbl[36];

  task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%b required=%b", nm, act, exp);
    end
  endtask

  task automatic chk3(input string nm, input logic [3:0] o, input logic [3:0] r,
                      input logic [3:0] f);
    chk({nm, ".out"},  key_out,  o);
    chk({nm, ".rise"}, key_rise, r);
    chk({nm, ".fall"}, key_fall, f);
  endtask

  task automatic set(input int i, input logic [3:0] in, input logic [3:0] o,
                     input logic [3:0] r, input logic [3:0] f);
    tbl[i].in   = in;
    tbl[i].out  = o;
    tbl[i].rise = r;
    tbl[i].fall = f;
  endtask

  initial begin
    // Rows 0-7: clean press on ch0, rise at t0+6.
    for (int i = 0; i < 8; i++) set(i, 4'b0001, (i >= 6) ? 4'b0001 : 4'b0000,
                                    (i == 6) ? 4'b0001 : 4'b0000, 4'b0000);
    // Rows 8-19: ch1 high 3, low 1, then steady high from t1 = row 12.
    for (int i = 8; i < 20; i++) set(i, (i == 11) ? 4'b0001 : 4'b0011,
                                     (i >= 18) ? 4'b0011 : 4'b0001,
                                     (i == 18) ? 4'b0010 : 4'b0000, 4'b0000);
    // Rows 20-27: ch0 release, fall at t2+6.
    for (int i = 20; i < 28; i++) set(i, 4'b0010, (i >= 26) ? 4'b0010 : 4'b0011,
                                      4'b0000, (i == 26) ? 4'b0001 : 4'b0000);
    // Rows 28-35: 2-cycle low glitch on ch1 is rejected.
    for (int i = 28; i < 36; i++) set(i, (i < 30) ? 4'b0000 : 4'b0010, 4'b0010,
                                      4'b0000, 4'b0000);

    clrn    = 1'b0;
    key_in  = 4'b0000;
    key_in2 = 4'b1111;

    for (int c = 0; c < 4; c++) begin
      key_in  = (c % 2 == 0) ? 4'b1111 : 4'b0000;
      key_in2 = ~key_in;
      @(posedge clk); #1;
      chk3($sformatf("reset_c%0d", c), 4'b0000, 4'b0000, 4'b0000);
      chk($sformatf("reset_al_out_c%0d", c), key_out2, 4'b0000);
      chk($sformatf("reset_al_rise_c%0d", c), key_rise2, 4'b0000);
    end
    key_in  = 4'b0000;
    key_in2 = 4'b1111;
    clrn    = 1'b1;
    @(posedge clk); #1;
    chk3("idle", 4'b0000, 4'b0000, 4'b0000);

    for (int i = 0; i < 36; i++) begin
      key_in = tbl[i].in;
      @(posedge clk); #1;
      chk3($sformatf("row%0d", i), tbl[i].out, tbl[i].rise, tbl[i].fall);
    end

    // Mid-count reset: ch2 pressed while ch1 already held.
    key_in = 4'b0110;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      chk3($sformatf("qual_c%0d", c), 4'b0010, 4'b0000, 4'b0000);
    end
    #2 clrn = 1'b0;
    #1 chk3("async_clear", 4'b0000, 4'b0000, 4'b0000);
    @(posedge clk); #1;
    chk3("in_reset", 4'b0000, 4'b0000, 4'b0000);
    clrn = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      chk3($sformatf("requal_c%0d", c), (c >= 6) ? 4'b0110 : 4'b0000,
           (c == 6) ? 4'b0110 : 4'b0000, 4'b0000);
    end

    // Active-low instance: all four pins pulled low together.
    key_in2 = 4'b0000;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      chk($sformatf("al_out_c%0d", c), key_out2, (c >= 6) ? 4'b1111 : 4'b0000);
      chk($sformatf("al_rise_c%0d", c), key_rise2, (c == 6) ? 4'b1111 : 4'b0000);
      chk($sformatf("al_fall_c%0d", c), key_fall2, 4'b0000);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
